// File: rtl/btn_step_generator.sv
// ============================================================================
// btn_step_generator
// ----------------------------------------------------------------------------
// Stimulus front end for the flip-flop lab boards. The raw center pushbutton
// is synchronized into the system clock domain and debounced. Each accepted
// press produces a single-cycle step pulse, captures the switch bank, and
// advances a wrapping step counter for the LED display. This way the
// flip-flop exercises advance exactly once per physical press.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive synchronized samples needed to accept a
//                     level change (>= 1). 1000000 is 10 ms at 100 MHz.
//   COUNT_W         : width of the step counter.
//
// Ports
//   i_clk        in   1        system clock, rising edge
//   i_resetN     in   1        synchronous active-low reset
//   i_btn        in   1        raw asynchronous pushbutton, high = pressed
//   i_sw         in   4        switch bank, captured on each accepted press
//   o_step       out  1        one-cycle pulse per accepted press
//   o_pressed    out  1        debounced button level
//   o_stim       out  4        switch value captured on the accepting edge
//   o_stepCount  out  COUNT_W  accepted presses, modulo 2^COUNT_W
// ============================================================================
module btn_step_generator #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_W         = 4
) (
  input  logic               i_clk,
  input  logic               i_resetN,
  input  logic               i_btn,
  input  logic [3:0]         i_sw,
  output logic               o_step,
  output logic               o_pressed,
  output logic [3:0]         o_stim,
  output logic [COUNT_W-1:0] o_stepCount
);

  // The counter holds values up to DEBOUNCE_CYCLES.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  // The counter already holds 1 when the first sample of a new level is taken.
  // So the DEBOUNCE_CYCLES-th consecutive sample is the one that arrives while
  // the counter holds DEBOUNCE_CYCLES-1. That sample is the accepting edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // With a single-sample debounce, the wait states are skipped entirely.
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic               r_syncStage1;
  logic               r_syncStage2;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_step;
  logic               r_pressed;
  logic [3:0]         r_stim;
  logic [COUNT_W-1:0] r_stepCount;

  logic               w_syncBtn;
  logic [1:0]         w_stateNext;
  logic [CNT_W-1:0]   w_cntNext;
  logic               w_pressAccept;
  logic               w_pressedNext;

  assign w_syncBtn = r_syncStage2;

  // Two-flop synchronizer for the asynchronous button. Nothing downstream
  // looks at i_btn directly. This keeps metastability out of the FSM and
  // the debounce counter.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_syncStage1 <= 1'b0;
      r_syncStage2 <= 1'b0;
    end else begin
      r_syncStage1 <= i_btn;
      r_syncStage2 <= r_syncStage1;
    end
  end

  // Debounce FSM next-state logic. Each wait state counts consecutive
  // samples of the candidate level. Any sample of the old level abandons
  // the candidate and returns to the stable state it came from, with the
  // count cleared. Only the press side raises w_pressAccept. A release, or
  // a bounce back into HELD, never produces a step.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_pressAccept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_syncBtn) begin
          if (SINGLE_SAMPLE) begin
            w_stateNext   = ST_HELD;
            w_cntNext     = '0;
            w_pressAccept = 1'b1;
          end else begin
            w_stateNext = ST_PRESS_WAIT;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_syncBtn) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext   = ST_HELD;
          w_cntNext     = '0;
          w_pressAccept = 1'b1;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!w_syncBtn) begin
          if (SINGLE_SAMPLE) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
          end else begin
            w_stateNext = ST_RELEASE_WAIT;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_syncBtn) begin
          w_stateNext = ST_HELD;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // The debounced level is high in both the held state and the release wait
  // state. The button is still considered pressed until the release has
  // been confirmed. It is computed from the next state so that it can be
  // registered and change on the same edge as the state.
  assign w_pressedNext = (w_stateNext == ST_HELD) || (w_stateNext == ST_RELEASE_WAIT);

  // State and debounce counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Registered outputs. On the edge that accepts a press, three updates
  // happen together: the step pulse, the switch capture, and the counter
  // increment. The counter wraps naturally at 2^COUNT_W. The step register
  // is rewritten every cycle, so the pulse lasts exactly one clock.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_step      <= 1'b0;
      r_pressed   <= 1'b0;
      r_stim      <= 4'h0;
      r_stepCount <= '0;
    end else begin
      r_step    <= w_pressAccept;
      r_pressed <= w_pressedNext;
      if (w_pressAccept) begin
        r_stim      <= i_sw;
        r_stepCount <= r_stepCount + COUNT_W'(1);
      end
    end
  end

  assign o_step      = r_step;
  assign o_pressed   = r_pressed;
  assign o_stim      = r_stim;
  assign o_stepCount = r_stepCount;

endmodule

// File: tb/tb_btn_step_generator.sv
// ============================================================================
// tb_btn_step_generator
// ----------------------------------------------------------------------------
// Directed bench for btn_step_generator. It drives two instances:
//   dut4 : DEBOUNCE_CYCLES=4. Used for reset, clean press, bounce, hold and
//          mid-press reset.
//   dut2 : DEBOUNCE_CYCLES=2. Used for the 17-press counter wrap.
// Each press pushes an expected step entry (edge index, captured switches,
// counter value) into a per-instance queue. A negedge monitor pops and
// compares an entry whenever that instance pulses its step output.
// ============================================================================
module tb_btn_step_generator;

  localparam int D4 = 4;
  localparam int D2 = 2;

  typedef struct {
    int         edgeIdx;
    logic [3:0] stim;
    logic [3:0] count;
  } stepExp_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic       btn4;
  logic       btn2;
  logic [3:0] sw4;
  logic [3:0] sw2;
  logic       step4;
  logic       step2;
  logic       pressed4;
  logic       pressed2;
  logic [3:0] stim4;
  logic [3:0] stim2;
  logic [3:0] count4;
  logic [3:0] count2;

  int         edgeNum = 0;
  int         compareCount = 0;
  int         failCount = 0;
  logic [3:0] expCount4 = 4'd0;
  logic [3:0] expCount2 = 4'd0;
  stepExp_t   q4[$];
  stepExp_t   q2[$];
  stepExp_t   e4;
  stepExp_t   e2;

  logic bouncePress[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic bounceRelease[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  btn_step_generator #(.DEBOUNCE_CYCLES(D4), .COUNT_W(4)) dut4 (
    .i_clk       (clk),
    .i_resetN    (resetN),
    .i_btn       (btn4),
    .i_sw        (sw4),
    .o_step      (step4),
    .o_pressed   (pressed4),
    .o_stim      (stim4),
    .o_stepCount (count4)
  );

  btn_step_generator #(.DEBOUNCE_CYCLES(D2), .COUNT_W(4)) dut2 (
    .i_clk       (clk),
    .i_resetN    (resetN),
    .i_btn       (btn2),
    .i_sw        (sw2),
    .o_step      (step2),
    .o_pressed   (pressed2),
    .o_stim      (stim2),
    .o_stepCount (count2)
  );

  always #5 clk = ~clk;

  // Edge index: after the n-th rising edge, edgeNum == n at the following negedge.
  always @(posedge clk) edgeNum <= edgeNum + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edgeNum);
    end
  endtask

  task applyStimulus(input int which, input logic b, input logic [3:0] s);
    if (which == 4) begin
      btn4 = b;
      sw4  = s;
    end else begin
      btn2 = b;
      sw2  = s;
    end
  endtask

  task automatic expectStep(input int which, input int edgeIdx, input logic [3:0] s);
    if (which == 4) begin
      expCount4 = expCount4 + 4'd1;
      q4.push_back('{edgeIdx: edgeIdx, stim: s, count: expCount4});
    end else begin
      expCount2 = expCount2 + 4'd1;
      q2.push_back('{edgeIdx: edgeIdx, stim: s, count: expCount2});
    end
  endtask

  task automatic waitAfter(input int e);
    while (edgeNum < e) @(negedge clk);
  endtask

  // Scoreboard monitors: every step pulse must match the oldest pending press.
  always @(negedge clk) begin
    if (step4 === 1'b1) begin
      if (q4.size() == 0) begin
        checkOutput("dut4 unexpected step", step4, 0);
      end else begin
        e4 = q4.pop_front();
        checkOutput("dut4 step edge", edgeNum, e4.edgeIdx);
        checkOutput("dut4 step stim", stim4, e4.stim);
        checkOutput("dut4 step count", count4, e4.count);
      end
    end
  end

  always @(negedge clk) begin
    if (step2 === 1'b1) begin
      if (q2.size() == 0) begin
        checkOutput("dut2 unexpected step", step2, 0);
      end else begin
        e2 = q2.pop_front();
        checkOutput("dut2 step edge", edgeNum, e2.edgeIdx);
        checkOutput("dut2 step stim", stim2, e2.stim);
        checkOutput("dut2 step count", count2, e2.count);
      end
    end
  end

  initial begin
    int p;
    int r;
    int k;
    int m;

    // Reset held for three edges with the button pressed and all switches on.
    resetN = 1'b0;
    applyStimulus(4, 1'b1, 4'hF);
    applyStimulus(2, 1'b1, 4'hF);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset step", step4, 0);
      checkOutput("reset pressed", pressed4, 0);
      checkOutput("reset stim", stim4, 0);
      checkOutput("reset count", count4, 0);
    end
    applyStimulus(4, 1'b0, 4'h0);
    applyStimulus(2, 1'b0, 4'h0);
    resetN = 1'b1;
    repeat (6) @(negedge clk);

    // Clean press: the button is first captured at edge p, and accepted at p+D+1.
    $display("[TB] clean press");
    p = edgeNum + 1;
    applyStimulus(4, 1'b1, 4'b1010);
    expectStep(4, p + D4 + 1, 4'b1010);
    waitAfter(p + D4);
    checkOutput("clean pressed before accept", pressed4, 0);
    waitAfter(p + D4 + 1);
    checkOutput("clean pressed at accept", pressed4, 1);
    checkOutput("clean count at accept", count4, expCount4);
    applyStimulus(4, 1'b1, 4'b0101);
    waitAfter(p + D4 + 2);
    checkOutput("clean step one cycle", step4, 0);
    waitAfter(p + 19);
    checkOutput("clean stim held", stim4, 4'b1010);
    applyStimulus(4, 1'b0, 4'b0101);
    r = p + 20;
    waitAfter(r + D4);
    checkOutput("clean pressed before release", pressed4, 1);
    waitAfter(r + D4 + 1);
    checkOutput("clean pressed after release", pressed4, 0);
    checkOutput("clean count after release", count4, expCount4);
    repeat (4) @(negedge clk);

    // Bounce on press: the last rising sample enters s1 at edge k+5.
    $display("[TB] bounce press");
    k = edgeNum + 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4, bouncePress[i], 4'b0110);
      @(negedge clk);
    end
    applyStimulus(4, 1'b1, 4'b0110);
    expectStep(4, k + 5 + D4 + 1, 4'b0110);
    waitAfter(k + 5 + D4);
    checkOutput("bounce pressed before accept", pressed4, 0);
    waitAfter(k + 20);
    checkOutput("bounce pressed held", pressed4, 1);

    // Bounce on release: the final low run starts at edge m+5.
    m = edgeNum + 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4, bounceRelease[i], 4'b0110);
      @(negedge clk);
    end
    applyStimulus(4, 1'b0, 4'b0110);
    waitAfter(m + 6);
    checkOutput("release bounce pressed", pressed4, 1);
    waitAfter(m + 5 + D4);
    checkOutput("release pressed before accept", pressed4, 1);
    waitAfter(m + 5 + D4 + 1);
    checkOutput("release pressed after accept", pressed4, 0);
    checkOutput("bounce count", count4, expCount4);
    repeat (4) @(negedge clk);

    // Long hold: only one step, and the debounced level stays high.
    $display("[TB] long hold");
    p = edgeNum + 1;
    applyStimulus(4, 1'b1, 4'b0011);
    expectStep(4, p + D4 + 1, 4'b0011);
    waitAfter(p + D4 + 1);
    checkOutput("hold pressed at accept", pressed4, 1);
    waitAfter(p + 1000);
    checkOutput("hold pressed after 1000", pressed4, 1);
    checkOutput("hold count", count4, expCount4);
    applyStimulus(4, 1'b0, 4'b0011);
    waitAfter(edgeNum + D4 + 4);
    checkOutput("hold released", pressed4, 0);

    // Reset at edges p+3 and p+4 of a press. The button is still high, so it
    // is recaptured at p+5 and accepted at p+10.
    $display("[TB] reset mid-press");
    p = edgeNum + 1;
    applyStimulus(4, 1'b1, 4'b1100);
    waitAfter(p + 2);
    resetN = 1'b0;
    waitAfter(p + 3);
    checkOutput("midreset pressed", pressed4, 0);
    checkOutput("midreset count", count4, 0);
    checkOutput("midreset stim", stim4, 0);
    waitAfter(p + 4);
    resetN = 1'b1;
    expCount4 = 4'd0;
    expectStep(4, p + 10, 4'b1100);
    waitAfter(p + 9);
    checkOutput("midreset pressed before accept", pressed4, 0);
    waitAfter(p + 10);
    checkOutput("midreset count after accept", count4, 1);
    applyStimulus(4, 1'b0, 4'b1100);
    waitAfter(edgeNum + D4 + 4);

    // Counter wrap on the D=2 instance: 17 clean presses give counts 1..15, 0, 1.
    $display("[TB] counter wrap");
    for (int n = 0; n < 17; n++) begin
      p = edgeNum + 1;
      applyStimulus(2, 1'b1, 4'(n));
      expectStep(2, p + D2 + 1, 4'(n));
      waitAfter(p + D2 + 1);
      checkOutput("wrap count", count2, expCount2);
      waitAfter(p + 6);
      applyStimulus(2, 1'b0, 4'(n));
      waitAfter(p + 6 + D2 + 3);
    end
    checkOutput("wrap final count", count2, 1);
    checkOutput("wrap released", pressed2, 0);

    repeat (3) @(negedge clk);
    checkOutput("dut4 pending steps", q4.size(), 0);
    checkOutput("dut2 pending steps", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
